booth_issue_sched: RTL

Synchronous issue/retire scheduler for the self-timed Booth radix multiplier pipeline. It round-robin arbitrates among N_REQ clocked requesters and injects one 512-bit operand word at a time into the first pipeline stage over that stage's four-phase request/acknowledge handshake. It accepts each result from the last stage over the same protocol and returns it to the originating requester through an in-order tag FIFO.

---
 rtl/booth_sched_pkg.sv | 25 ++
 rtl/hs_sync.sv | 26 ++
 rtl/booth_issue_sched.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/booth_sched_pkg.sv
// Shared types and helpers for the Booth multiplier issue/retire scheduler.
package booth_sched_pkg;

  localparam int unsigned DefaultDw = 512;

  typedef logic [1:0] issue_state_t;
  localparam issue_state_t IssueIdle = 2'd0;
  localparam issue_state_t IssueHi   = 2'd1;
  localparam issue_state_t IssueLo   = 2'd2;

  typedef logic ret_state_t;
  localparam ret_state_t RetIdle = 1'b0;
  localparam ret_state_t RetLo   = 1'b1;

  // Ceiling log2, usable in parameter expressions.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/hs_sync.sv
// Reset-to-zero multi-flop synchronizer for a single asynchronous handshake wire.
module hs_sync #(
  parameter int unsigned Stages = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [Stages-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < int'(Stages); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/booth_issue_sched.sv
// Round-robin issue of operand words into a self-timed multiplier pipeline and in-order
// return of results to their requesters through a tag FIFO.
module booth_issue_sched
  import booth_sched_pkg::*;
#(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned DW     = DefaultDw,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned SYNC   = 2,
  localparam int unsigned IdW   = clog2(N_REQ),
  localparam int unsigned PtrW  = clog2(DEPTH)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [N_REQ-1:0]    req_valid_i,
  input  logic [N_REQ*DW-1:0] req_data_i,
  output logic [N_REQ-1:0]    req_ready_o,
  output logic                pipe_rin_o,
  input  logic                pipe_ain_i,
  output logic [DW-1:0]       pipe_data_o,
  input  logic                tail_rout_i,
  output logic                tail_aout_o,
  input  logic [DW-1:0]       tail_data_i,
  output logic                rsp_valid_o,
  output logic [IdW-1:0]      rsp_id_o,
  output logic [DW-1:0]       rsp_data_o,
  input  logic                rsp_ready_i,
  output logic                err_o
);

  localparam logic [PtrW:0] FullCnt = (PtrW+1)'(DEPTH);

  logic ain_s, rout_s;

  hs_sync #(.Stages(SYNC)) u_sync_ain (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (pipe_ain_i),
    .q_o    (ain_s)
  );

  hs_sync #(.Stages(SYNC)) u_sync_rout (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (tail_rout_i),
    .q_o    (rout_s)
  );

  issue_state_t     issue_q, issue_d;
  logic [IdW-1:0]   ptr_q, ptr_d;
  logic [N_REQ-1:0] ready_q, ready_d;
  logic             rin_q, rin_d;
  logic [DW-1:0]    pdata_q, pdata_d;

  ret_state_t       ret_q, ret_d;
  logic             aout_q, aout_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IdW-1:0]   rsp_id_q, rsp_id_d;
  logic [DW-1:0]    rsp_data_q, rsp_data_d;
  logic             err_q, err_d;

  logic [IdW-1:0]   tag_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    cnt_q;

  logic             fifo_full, fifo_empty, push, pop, issue_go, ret_go;
  logic             grant_found;
  logic [IdW-1:0]   grant_id, scan_idx;

  // First requester with valid set, scanning upward from the pointer with wrap-around.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = ptr_q;
    scan_idx    = ptr_q;
    for (int k = 0; k < int'(N_REQ); k++) begin
      scan_idx = ptr_q + IdW'(k);
      if (!grant_found && req_valid_i[scan_idx]) begin
        grant_found = 1'b1;
        grant_id    = scan_idx;
      end
    end
  end

  assign fifo_full  = (cnt_q == FullCnt);
  assign fifo_empty = (cnt_q == '0);
  assign issue_go   = (issue_q == IssueIdle) && grant_found && !fifo_full;
  assign ret_go     = (ret_q == RetIdle) && rout_s && !rsp_valid_q;
  assign push       = issue_go;
  assign pop        = ret_go && !fifo_empty;

  always_comb begin
    issue_d = issue_q;
    ptr_d   = ptr_q;
    ready_d = '0;
    rin_d   = rin_q;
    pdata_d = pdata_q;
    case (issue_q)
      IssueIdle: begin
        rin_d = 1'b0;
        if (issue_go) begin
          ready_d[grant_id] = 1'b1;
          pdata_d           = req_data_i[grant_id*DW +: DW];
          ptr_d             = grant_id + IdW'(1);
          issue_d           = IssueHi;
        end
      end
      IssueHi: begin
        rin_d = 1'b1;
        if (ain_s) begin
          rin_d   = 1'b0;
          issue_d = IssueLo;
        end
      end
      IssueLo: begin
        rin_d = 1'b0;
        if (!ain_s) issue_d = IssueIdle;
      end
      default: begin
        rin_d   = 1'b0;
        issue_d = IssueIdle;
      end
    endcase
  end

  // tail_data is bundled with tail_rout, so it is settled once rout has crossed the synchronizer.
  always_comb begin
    ret_d       = ret_q;
    aout_d      = aout_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    err_d       = err_q;
    if (rsp_valid_q && rsp_ready_i) rsp_valid_d = 1'b0;
    case (ret_q)
      RetIdle: begin
        if (ret_go) begin
          rsp_data_d  = tail_data_i;
          rsp_id_d    = fifo_empty ? '0 : tag_q[rd_ptr_q];
          err_d       = err_q | fifo_empty;
          rsp_valid_d = 1'b1;
          aout_d      = 1'b1;
          ret_d       = RetLo;
        end
      end
      RetLo: begin
        if (!rout_s) begin
          aout_d = 1'b0;
          ret_d  = RetIdle;
        end
      end
      default: begin
        aout_d = 1'b0;
        ret_d  = RetIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      issue_q     <= IssueIdle;
      ptr_q       <= '0;
      ready_q     <= '0;
      rin_q       <= 1'b0;
      pdata_q     <= '0;
      ret_q       <= RetIdle;
      aout_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      issue_q     <= issue_d;
      ptr_q       <= ptr_d;
      ready_q     <= ready_d;
      rin_q       <= rin_d;
      pdata_q     <= pdata_d;
      ret_q       <= ret_d;
      aout_q      <= aout_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tag_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        tag_q[wr_ptr_q] <= grant_id;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (pop && !push) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  assign req_ready_o = ready_q;
  assign pipe_rin_o  = rin_q;
  assign pipe_data_o = pdata_q;
  assign tail_aout_o = aout_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_data_o  = rsp_data_q;
  assign err_o       = err_q;

endmodule
